// File: rtl/pmp_checker_seq_if.sv
// pmp_checker_seq_if: request/response bundle of the sequential PMP checker.
// master = requester (LSU/fetch), slave = checker.
interface pmp_checker_seq_if #(
    parameter int PLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [PLEN-1:0] req_addr;
    logic [1:0]      req_size;
    logic [1:0]      req_priv;
    logic [1:0]      req_oper;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_fault;
    logic [3:0]      resp_cause;

    modport master (
        output req_valid, req_addr, req_size, req_priv, req_oper,
        output resp_ready,
        input  req_ready, resp_valid, resp_fault, resp_cause
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_priv, req_oper,
        input  resp_ready,
        output req_ready, resp_valid, resp_fault, resp_cause
    );
endinterface

// File: rtl/pmp_checker_seq.sv
// pmp_checker_seq: multi-cycle PMP checker, LANES entries per scan cycle.
// Define PMP_DENY_CNT_EN to add a saturating deny_cnt output.
module pmp_checker_seq #(
    parameter int NUM_ENTRIES = 16,
    parameter int LANES       = 4,
    parameter int PLEN        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef PMP_DENY_CNT_EN
    output logic [15:0]                   deny_cnt,
`endif
    input  logic [NUM_ENTRIES*(PLEN-2)-1:0] pmpaddr_flat,
    input  logic [NUM_ENTRIES*8-1:0]      pmpcfg_flat,
    input  logic                          csr_wr_pulse,
    pmp_checker_seq_if.slave              bus
);
    localparam int AW = PLEN - 2;
    localparam int NG = NUM_ENTRIES / LANES;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic [GW-1:0]   group;
    logic [PLEN-1:0] a_addr;
    logic [1:0]      a_size;
    logic [1:0]      a_priv;
    logic [1:0]      a_oper;
    logic            fault_q;
    logic [3:0]      cause_q;

    logic [AW-1:0] ent_addr [NUM_ENTRIES];
    logic [1:0]    ent_mode [NUM_ENTRIES];
    logic [2:0]    ent_perm [NUM_ENTRIES];
    logic          ent_lock [NUM_ENTRIES];
    logic [NUM_ENTRIES*2-1:0] cfg_rsvd;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_unpack
        assign ent_addr[i] = pmpaddr_flat[i*AW +: AW];
        assign ent_perm[i] = pmpcfg_flat[i*8 +: 3];
        assign ent_mode[i] = pmpcfg_flat[i*8+3 +: 2];
        assign cfg_rsvd[i*2 +: 2] = pmpcfg_flat[i*8+5 +: 2];
        assign ent_lock[i] = pmpcfg_flat[i*8+7];
    end

    function automatic logic entry_match(
        input logic [1:0]    mode,
        input logic [AW-1:0] w,
        input logic [AW-1:0] cur,
        input logic [AW-1:0] prv
    );
        logic [AW-1:0] mask;
        // Clears the trailing-ones run and the zero above it.
        mask = ~(cur ^ (cur + AW'(1)));
        unique case (mode)
            2'b01:   return (w >= prv) && (w < cur);
            2'b10:   return w == cur;
            2'b11:   return (w & mask) == (cur & mask);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic oper_perm(
        input logic [1:0] op,
        input logic [2:0] p
    );
        unique case (op)
            2'b00:   return p[0];
            2'b01:   return p[1];
            2'b10:   return p[2];
            default: return 1'b0;
        endcase
    endfunction

    logic [PLEN-1:0] span;
    logic [PLEN-1:0] hi_addr;
    logic [AW-1:0]   lo_w;
    logic [AW-1:0]   hi_w;

    // Last byte offset of the access; size 11 behaves as a word.
    always_comb begin
        unique case (a_size)
            2'b00:   span = '0;
            2'b01:   span = PLEN'(1);
            default: span = PLEN'(3);
        endcase
    end

    assign hi_addr = a_addr + span;
    assign lo_w    = a_addr[PLEN-1:2];
    assign hi_w    = hi_addr[PLEN-1:2];

    logic unused_bits;
    assign unused_bits = ^{cfg_rsvd, hi_addr[1:0]};

    logic [IW-1:0] idx;
    logic [AW-1:0] prv_addr;
    logic          m_lo;
    logic          m_hi;
    logic          perm_ok;
    logic          hit_found;
    logic          hit_fault;

    // Evaluate the current lane group; walking down leaves the lowest hit.
    always_comb begin
        idx       = '0;
        prv_addr  = '0;
        m_lo      = 1'b0;
        m_hi      = 1'b0;
        perm_ok   = 1'b0;
        hit_found = 1'b0;
        hit_fault = 1'b0;
        for (int l = LANES - 1; l >= 0; l--) begin
            idx = IW'(int'(group) * LANES + l);
            prv_addr = (idx == '0) ? '0 : ent_addr[idx - IW'(1)];
            m_lo = entry_match(ent_mode[idx], lo_w,
                               ent_addr[idx], prv_addr);
            m_hi = entry_match(ent_mode[idx], hi_w,
                               ent_addr[idx], prv_addr);
            perm_ok = ((a_priv == 2'b11) && !ent_lock[idx])
                    || oper_perm(a_oper, ent_perm[idx]);
            if (m_lo || m_hi) begin
                hit_found = 1'b1;
                hit_fault = (m_lo != m_hi) || !perm_ok;
            end
        end
    end

    logic       res_fault;
    logic [3:0] res_cause;

    // Reserved operation 11 is refused whatever the entries say.
    assign res_fault = (a_oper == 2'b11)
                     || (hit_found ? hit_fault : (a_priv != 2'b11));
    assign res_cause = (a_oper == 2'b10) ? 4'd1 :
                       (a_oper == 2'b00) ? 4'd5 : 4'd7;

    // Accept, scan group by group, hold the registered result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            group   <= '0;
            a_addr  <= '0;
            a_size  <= '0;
            a_priv  <= '0;
            a_oper  <= '0;
            fault_q <= 1'b0;
            cause_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        a_addr <= bus.req_addr;
                        a_size <= bus.req_size;
                        a_priv <= bus.req_priv;
                        a_oper <= bus.req_oper;
                        group  <= '0;
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (csr_wr_pulse) begin
                        group <= '0;
                    end else if (hit_found || group == LAST_G) begin
                        fault_q <= res_fault;
                        cause_q <= res_fault ? res_cause : 4'd0;
                        state   <= S_RESP;
                    end else begin
                        group <= group + GW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_fault = fault_q;
    assign bus.resp_cause = cause_q;

`ifdef PMP_DENY_CNT_EN
    // Count faulting responses consumed by the requester, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deny_cnt <= '0;
        end else if (state == S_RESP && bus.resp_ready && fault_q
                     && deny_cnt != 16'hFFFF) begin
            deny_cnt <= deny_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pmp_checker_seq.sv
// tb_pmp_checker_seq: directed and random checks of pmp_checker_seq
// against a range-based reference model of the PMP rules.
module tb_pmp_checker_seq;
    localparam int N  = 16;
    localparam int L  = 4;
    localparam int PL = 32;
    localparam int AW = PL - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N*AW-1:0] pmpaddr_flat;
    logic [N*8-1:0]  pmpcfg_flat;
    logic            csr_wr_pulse;
`ifdef PMP_DENY_CNT_EN
    logic [15:0]     deny_cnt;
`endif

    pmp_checker_seq_if #(.PLEN(PL)) bus ();

    pmp_checker_seq #(
        .NUM_ENTRIES(N),
        .LANES(L),
        .PLEN(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef PMP_DENY_CNT_EN
        .deny_cnt(deny_cnt),
`endif
        .pmpaddr_flat(pmpaddr_flat),
        .pmpcfg_flat(pmpcfg_flat),
        .csr_wr_pulse(csr_wr_pulse),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each entry is a half-open word range; first hit decides.
    function automatic void model(
        input logic [31:0] a, input logic [1:0] s,
        input logic [1:0] p, input logic [1:0] o,
        output logic f, output logic [3:0] c, output int lat
    );
        longint unsigned lw, hw, cur, prv, rl, rh;
        logic [7:0] cfg;
        bit hit_lo, hit_hi, ok, done;
        int k, nb;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        lw = {32'd0, a} >> 2;
        hw = (({32'd0, a} + 64'(nb - 1)) & 64'hFFFF_FFFF) >> 2;
        done = 0;
        ok = 0;
        lat = N / L + 1;
        for (int i = 0; i < N; i++) begin
            if (!done) begin
                cfg = pmpcfg_flat[i*8 +: 8];
                cur = 64'(pmpaddr_flat[i*AW +: AW]);
                prv = (i == 0) ? 64'd0 : 64'(pmpaddr_flat[(i-1)*AW +: AW]);
                rl = 0;
                rh = 0;
                case (cfg[4:3])
                    2'b01: begin rl = prv; rh = cur; end
                    2'b10: begin rl = cur; rh = cur + 1; end
                    2'b11: begin
                        k = 0;
                        while (k < AW && cur[k]) k++;
                        rl = cur - ((64'd1 << k) - 1);
                        rh = rl + (64'd1 << (k + 1));
                    end
                    default: ;
                endcase
                hit_lo = (lw >= rl) && (lw < rh);
                hit_hi = (hw >= rl) && (hw < rh);
                if (hit_lo || hit_hi) begin
                    done = 1;
                    lat = i / L + 2;
                    if (hit_lo != hit_hi) ok = 0;
                    else if (p == 2'b11 && !cfg[7]) ok = 1;
                    else begin
                        case (o)
                            2'd0: ok = cfg[0];
                            2'd1: ok = cfg[1];
                            2'd2: ok = cfg[2];
                            default: ok = 0;
                        endcase
                    end
                end
            end
        end
        if (!done) ok = (p == 2'b11);
        if (o == 2'b11) ok = 0;
        f = !ok;
        c = ok ? 4'd0 : (o == 2'd2) ? 4'd1 : (o == 2'd0) ? 4'd5 : 4'd7;
    endfunction

    bit         pend = 0;
    int         cyc = 0;
    int         exp_lat = 0;
    int         base_lat = 0;
    logic       exp_f = 0;
    logic [3:0] exp_c = 0;
    int         model_deny = 0;

    // Track each accepted request through the model (pre-edge values).
    always @(posedge clk) begin
        if (!rst) begin
            if (pend) begin
                if (bus.resp_valid && bus.resp_ready) begin
                    pend = 0;
                    if (exp_f && model_deny < 65535) model_deny++;
                end else begin
                    if (csr_wr_pulse && cyc < exp_lat)
                        exp_lat = cyc + base_lat;
                    cyc++;
                end
            end else if (bus.req_valid && bus.req_ready) begin
                model(bus.req_addr, bus.req_size, bus.req_priv,
                      bus.req_oper, exp_f, exp_c, base_lat);
                exp_lat = base_lat;
                cyc = 1;
                pend = 1;
            end
        end
    end

    // Compare DUT outputs with the model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_req_ready", bus.req_ready, 1);
            check("rst_fault", bus.resp_fault, 0);
            check("rst_cause", bus.resp_cause, 0);
        end else if (pend) begin
            check("busy_req_ready", bus.req_ready, 0);
            check("resp_valid_timing", bus.resp_valid, cyc >= exp_lat);
            if (cyc >= exp_lat) begin
                check("resp_fault", bus.resp_fault, exp_f);
                check("resp_cause", bus.resp_cause, exp_c);
            end
        end else begin
            check("idle_resp_valid", bus.resp_valid, 0);
            check("idle_req_ready", bus.req_ready, 1);
        end
    end

    task automatic clr_cfg();
        pmpaddr_flat = '0;
        pmpcfg_flat = '0;
    endtask

    task automatic set_ent(input int i, input logic [AW-1:0] a,
                           input logic [7:0] c);
        pmpaddr_flat[i*AW +: AW] = a;
        pmpcfg_flat[i*8 +: 8] = c;
    endtask

    // Called #1 after an edge with the checker idle; returns likewise.
    task automatic req(
        input logic [31:0] a, input logic [1:0] s,
        input logic [1:0] p, input logic [1:0] o,
        input int hold, input bit pulse,
        output logic f, output logic [3:0] c, output int lat
    );
        check("pre_req_ready", bus.req_ready, 1);
        bus.req_addr = a;
        bus.req_size = s;
        bus.req_priv = p;
        bus.req_oper = o;
        bus.req_valid = 1'b1;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (pulse) csr_wr_pulse = 1'b1;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            csr_wr_pulse = 1'b0;
            lat++;
        end
        csr_wr_pulse = 1'b0;
        f = bus.resp_fault;
        c = bus.resp_cause;
        for (int i = 0; i < hold; i++) begin
            csr_wr_pulse = (i == 0);
            @(posedge clk);
            #1;
            csr_wr_pulse = 1'b0;
            check("hold_valid", bus.resp_valid, 1);
            check("hold_fault", bus.resp_fault, f);
            check("hold_cause", bus.resp_cause, c);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic dir(
        input string name, input logic [31:0] a, input logic [1:0] s,
        input logic [1:0] p, input logic [1:0] o, input int hold,
        input bit pulse, input logic ef, input logic [3:0] ec, input int el
    );
        logic f, mf;
        logic [3:0] c, mc;
        int lat, ml;
        model(a, s, p, o, mf, mc, ml);
        check({name, "_model_fault"}, mf, ef);
        check({name, "_model_cause"}, mc, ec);
        check({name, "_model_lat"}, ml + int'(pulse), el);
        req(a, s, p, o, hold, pulse, f, c, lat);
        check({name, "_fault"}, f, ef);
        check({name, "_cause"}, c, ec);
        check({name, "_lat"}, lat, el);
    endtask

    task automatic rand_cfg();
        logic [1:0] mode;
        logic [AW-1:0] a;
        int k;
        for (int i = 0; i < N; i++) begin
            mode = 2'($urandom_range(0, 3));
            a = AW'($urandom_range(0, 'h3FF));
            if (mode == 2'b11) begin
                k = $urandom_range(0, 8);
                a = (a & ~AW'((1 << (k + 1)) - 1)) | AW'((1 << k) - 1);
                if ($urandom_range(0, 15) == 0) a = '1;
            end
            set_ent(i, a, {($urandom_range(0, 3) == 0), 2'b00,
                           mode, 3'($urandom)});
        end
    endtask

    logic       rf;
    logic [3:0] rc;
    int         rl;
    logic [31:0] ra;
    logic [15:0] d0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_size = '0;
        bus.req_priv = '0;
        bus.req_oper = '0;
        bus.resp_ready = 1'b1;
        csr_wr_pulse = 1'b0;
        clr_cfg();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_ent(0, 30'h400, 8'h0D);
        dir("tor_u_load", 32'h800, 2'd2, 2'd0, 2'd0, 0, 0, 0, 4'd0, 2);
        dir("tor_u_store", 32'h800, 2'd2, 2'd0, 2'd1, 0, 0, 1, 4'd7, 2);
        dir("tor_m_store", 32'h800, 2'd2, 2'd3, 2'd1, 0, 0, 0, 4'd0, 2);
        set_ent(0, 30'h400, 8'h8D);
        dir("lock_m_store", 32'h800, 2'd2, 2'd3, 2'd1, 0, 0, 1, 4'd7, 2);
        dir("lock_m_load", 32'h800, 2'd2, 2'd3, 2'd0, 0, 0, 0, 4'd0, 2);
        set_ent(0, 30'h400, 8'h0D);
        dir("straddle", 32'hFFE, 2'd2, 2'd0, 2'd0, 0, 0, 1, 4'd5, 2);
        dir("straddle_m", 32'hFFE, 2'd2, 2'd3, 2'd0, 0, 0, 1, 4'd5, 2);
        dir("tor_top", 32'hFFC, 2'd2, 2'd0, 2'd0, 0, 0, 0, 4'd0, 2);
        dir("wrap", 32'hFFFF_FFFE, 2'd2, 2'd0, 2'd0, 0, 0, 1, 4'd5, 2);

        clr_cfg();
        set_ent(5, 30'h0800_01FF, 8'h1B);
        dir("napot_store", 32'h2000_0FFC, 2'd2, 2'd0, 2'd1, 0, 0,
            0, 4'd0, 3);
        dir("napot_fetch", 32'h2000_0FFC, 2'd2, 2'd0, 2'd2, 0, 0,
            1, 4'd1, 3);
        dir("napot_out", 32'h2000_1000, 2'd2, 2'd0, 2'd0, 0, 0,
            1, 4'd5, 5);
        dir("csr_restart", 32'h2000_0000, 2'd2, 2'd0, 2'd0, 0, 1,
            0, 4'd0, 4);
        dir("hold5", 32'h2000_0000, 2'd2, 2'd0, 2'd0, 5, 0, 0, 4'd0, 3);

        clr_cfg();
        dir("off_u_load", 32'h2000_1000, 2'd2, 2'd0, 2'd0, 0, 0,
            1, 4'd5, 5);
        dir("off_m_load", 32'h2000_1000, 2'd0, 2'd3, 2'd0, 0, 0,
            0, 4'd0, 5);
        dir("oper11", 32'h100, 2'd0, 2'd3, 2'd3, 0, 0, 1, 4'd7, 5);
        set_ent(2, '1, 8'h18);
        dir("napot_all", 32'h1234_5678, 2'd1, 2'd0, 2'd0, 0, 0,
            1, 4'd5, 2);
        clr_cfg();
        set_ent(2, 30'h500, 8'h00);
        set_ent(3, 30'h400, 8'h0F);
        dir("tor_inverted", 32'h1200, 2'd0, 2'd0, 2'd0, 0, 0,
            1, 4'd5, 5);

        clr_cfg();
        bus.req_addr = 32'h40;
        bus.req_size = 2'd2;
        bus.req_priv = 2'd0;
        bus.req_oper = 2'd0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_resp_valid", bus.resp_valid, 0);
        check("post_rst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        check("post_rst2_resp_valid", bus.resp_valid, 0);
        check("post_rst2_req_ready", bus.req_ready, 1);

`ifdef PMP_DENY_CNT_EN
        check("deny_after_rst", deny_cnt, 0);
        model_deny = 0;
        d0 = deny_cnt;
        for (int i = 0; i < 3; i++)
            dir("deny_req", 32'h80, 2'd2, 2'd0, 2'd1, 0, 0, 1, 4'd7, 5);
        check("deny_cnt3", deny_cnt - d0, 3);
`else
        d0 = '0;
`endif

        for (int t = 0; t < 300; t++) begin
            if (t % 4 == 0) begin
                rand_cfg();
                csr_wr_pulse = 1'b1;
                @(posedge clk);
                #1;
                csr_wr_pulse = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 15) == 0)
                ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else
                ra = 32'($urandom_range(0, 'h1003));
            req(ra, 2'($urandom), 2'($urandom), 2'($urandom),
                $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                rf, rc, rl);
            check("rnd_no_timeout", rl < 100, 1);
        end

`ifdef PMP_DENY_CNT_EN
        check("deny_cnt_total", deny_cnt - d0, 16'(model_deny));
`endif
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
